vm_cfg_master: RTL

- APB-style configuration initiator for the vending machine's item table.
- Accepts item-level read/write commands from a local controller (boot loader or test sequencer) on a valid/ready interface and converts each into bus transfers on psel/pwrite/paddr/pwdata/prdata/pready.
- Optionally performs a readback after each write to verify it, and drives the cfg_mode request line.
- Lives in the config clock domain, on the initiator side of the vending machine's config bus.

---
 rtl/vm_cfg_master_if.sv | 30 +++
 rtl/vm_cfg_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vm_cfg_master_if.sv
// rtl/vm_cfg_master_if.sv - command, response and config-bus signals of vm_cfg_master
interface vm_cfg_master_if #(
    parameter int IW = 10
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic          cmd_verify;
    logic [IW-1:0] cmd_item;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [31:0]   rsp_rdata;
    logic          psel;
    logic          pwrite;
    logic [14:0]   paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_verify, cmd_item, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_status, rsp_rdata, psel, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_verify, cmd_item, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_rdata, psel, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/vm_cfg_master.sv
// rtl/vm_cfg_master.sv - config-bus initiator turning item commands into bus transfers
module vm_cfg_master #(
    parameter int MAX_ITEMS      = 1024,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        pclk,
    input  logic        prstn,
    input  logic        cfg_hold,
    output logic        cfg_mode,
    output logic [15:0] txn_count,
    vm_cfg_master_if.master bus
);
    localparam int IW = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_VFAIL   = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_SETUP, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic          verify_q, verify_d;
    logic          rb_q, rb_d;
    logic [IW-1:0] item_q, item_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    status_q, status_d;
    logic [15:0]   txn_q, txn_d;
    logic          pwrite_q, pwrite_d;
    logic [14:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          cfg_mode_q;

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            verify_q   <= 1'b0;
            rb_q       <= 1'b0;
            item_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= ST_OK;
            txn_q      <= '0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            cfg_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            verify_q   <= verify_d;
            rb_q       <= rb_d;
            item_q     <= item_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            txn_q      <= txn_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            cfg_mode_q <= cfg_hold | (state_q != S_IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        verify_d = verify_q;
        rb_d     = rb_q;
        item_d   = item_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        txn_d    = txn_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    write_d  = bus.cmd_write;
                    verify_d = bus.cmd_verify;
                    item_d   = bus.cmd_item;
                    wdata_d  = bus.cmd_wdata;
                    rb_d     = 1'b0;
                    rdata_d  = '0;
                    status_d = ST_OK;
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end
            end
            // The responder keeps pready high until it sees psel drop.
            S_GAP: begin
                if (!bus.pready) begin
                    cnt_d    = '0;
                    pwrite_d = write_q & ~rb_q;
                    paddr_d  = 15'd4 + 15'({item_q, 2'b00});
                    pwdata_d = wdata_q;
                    state_d  = S_SETUP;
                end else if (cnt_q == T_LAST) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_SETUP: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.pready) begin
                    txn_d = txn_q + 16'd1;
                    if (!pwrite_q) rdata_d = bus.prdata;
                    if (pwrite_q && verify_q) begin
                        rb_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        if (rb_q && (bus.prdata != wdata_q)) status_d = ST_VFAIL;
                        state_d = S_RESP;
                    end
                end else if (cnt_q == T_LAST) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = (state_q == S_IDLE);
        bus.psel       = (state_q == S_SETUP) || (state_q == S_WAIT);
        bus.rsp_valid  = (state_q == S_RESP);
        bus.rsp_status = status_q;
        bus.rsp_rdata  = rdata_q;
        bus.pwrite     = pwrite_q;
        bus.paddr      = paddr_q;
        bus.pwdata     = pwdata_q;
        cfg_mode       = cfg_mode_q;
        txn_count      = txn_q;
    end
endmodule
